// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency single-port memory between instruction fetch and data access.
// Define ARB_PERF_EN to add saturating stall-cycle counters perf_if_wait / perf_dm_wait.
module mem_port_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned LATENCY = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_done,
  output logic [DW-1:0]   if_rdata,
  output logic            if_stall,
  input  logic            dm_req,
  input  logic            dm_we,
  input  logic [AW-1:0]   dm_addr,
  input  logic [DW-1:0]   dm_wdata,
  input  logic [DW/8-1:0] dm_wstrb,
  output logic            dm_done,
  output logic [DW-1:0]   dm_rdata,
  output logic            dm_stall,
  output logic            mem_en,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wstrb,
  input  logic [DW-1:0]   mem_rdata
`ifdef ARB_PERF_EN
  ,
  output logic [31:0]     perf_if_wait,
  output logic [31:0]     perf_dm_wait
`endif
);

  localparam int unsigned SW = DW / 8;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;
  typedef enum logic [1:0] {OwnNone, OwnIf, OwnDm} owner_e;

  state_e          state_q, state_d;
  owner_e          owner_q, owner_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            mem_en_q, mem_en_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [SW-1:0]   wstrb_q, wstrb_d;
  logic            if_done_q, if_done_d;
  logic            dm_done_q, dm_done_d;
  logic [DW-1:0]   if_rdata_q, if_rdata_d;
  logic [DW-1:0]   dm_rdata_q, dm_rdata_d;
  logic            grant_if, grant_dm;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    mem_en_d   = 1'b0;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    if_done_d  = 1'b0;
    dm_done_d  = 1'b0;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    grant_if   = 1'b0;
    grant_dm   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (dm_req) begin
          grant_dm = 1'b1;
        end else if (if_req) begin
          grant_if = 1'b1;
        end
      end
      StIssue: begin
        state_d = StWait;
        cnt_d   = 4'(LATENCY - 1);
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StResp;
          if (owner_q == OwnDm) begin
            dm_done_d = 1'b1;
            if (!we_q) begin
              dm_rdata_d = mem_rdata;
            end
          end else begin
            if_done_d  = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        // The owner's req is still high during its done cycle, so only the other side may win.
        if (owner_q == OwnDm && if_req) begin
          grant_if = 1'b1;
        end else if (owner_q == OwnIf && dm_req) begin
          grant_dm = 1'b1;
        end else begin
          state_d = StIdle;
          owner_d = OwnNone;
        end
      end
      default: state_d = StIdle;
    endcase

    if (grant_dm) begin
      state_d  = StIssue;
      owner_d  = OwnDm;
      mem_en_d = 1'b1;
      we_d     = dm_we;
      addr_d   = dm_addr;
      wdata_d  = dm_wdata;
      wstrb_d  = dm_we ? dm_wstrb : '0;
    end else if (grant_if) begin
      state_d  = StIssue;
      owner_d  = OwnIf;
      mem_en_d = 1'b1;
      we_d     = 1'b0;
      addr_d   = if_addr;
      wdata_d  = '0;
      wstrb_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      owner_q    <= OwnNone;
      cnt_q      <= 4'd0;
      mem_en_q   <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      if_done_q  <= 1'b0;
      dm_done_q  <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      mem_en_q   <= mem_en_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      if_done_q  <= if_done_d;
      dm_done_q  <= dm_done_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wstrb = wstrb_q;
  assign if_done   = if_done_q;
  assign dm_done   = dm_done_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_stall  = if_req & ~if_done_q;
  assign dm_stall  = dm_req & ~dm_done_q;

`ifdef ARB_PERF_EN
  logic [31:0] perf_if_q, perf_dm_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_if_q <= 32'd0;
      perf_dm_q <= 32'd0;
    end else begin
      if (if_stall && perf_if_q != 32'hFFFF_FFFF) begin
        perf_if_q <= perf_if_q + 32'd1;
      end
      if (dm_stall && perf_dm_q != 32'hFFFF_FFFF) begin
        perf_dm_q <= perf_dm_q + 32'd1;
      end
    end
  end

  assign perf_if_wait = perf_if_q;
  assign perf_dm_wait = perf_dm_q;
`endif

endmodule
